muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and half-result width (even, >= 8).
REQ-002 The block SHALL have parameter MUL_ITER, default 1: 1 = iterative shift-add multiply; 0 = single-cycle multiply.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port op, input, 5 bits: ALU control code; MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL and DIVU_CONTROL are recognised.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin op on a and b.
REQ-007 The block SHALL have port flush, input, 1 bit: abort any operation in flight.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits: dividend/multiplicand and divisor/multiplier.
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in flight, so the pipeline must stall.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking hi/lo valid.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH bits: product high/low, or remainder/quotient.

Function
REQ-012 The block SHALL implement the states IDLE, MUL, DIV and FIN.
REQ-013 The block SHALL accept start only in IDLE with a recognised op; start in any other state or with an unrecognised op is ignored (no state change, no done).
REQ-014 On accept, the block SHALL capture operand magnitudes (signed ops) or raw values (unsigned ops) plus result-sign flags, load counter = WIDTH, and enter MUL or DIV.
REQ-015 MUL/DIV SHALL perform one radix-2 step per cycle, decrementing the counter, and SHALL enter FIN when the counter reaches 0; start edge to done = WIDTH+1 cycles.
REQ-016 With MUL_ITER=0, accepted multiplies SHALL enter FIN directly, so done rises 1 cycle after the start edge.
REQ-017 In FIN, the block SHALL apply sign correction, register hi/lo, pulse done for exactly 1 cycle and return to IDLE.
REQ-018 The block SHALL drive busy high in MUL, DIV and FIN and low in IDLE.
REQ-019 Product sign SHALL be sign(a) XOR sign(b); quotient takes the same sign, and the remainder takes the sign of a.
REQ-020 For division by zero, the block SHALL return lo = all ones and hi = a, with normal latency.
REQ-021 For signed most-negative / -1, the block SHALL return lo = most-negative and hi = 0.
REQ-022 A flush in any state SHALL force IDLE at the next edge, suppress done, and leave hi/lo unchanged.
REQ-023 When flush and start are asserted in the same cycle, flush SHALL win and start is dropped.
REQ-024 hi/lo SHALL hold their last value until the next FIN.
REQ-025 A new start SHALL be accepted in the cycle after done (from IDLE).

Reset
REQ-026 resetn low SHALL immediately force IDLE; busy=0, done=0, hi=0, lo=0, counter=0, regardless of any operation in progress.
REQ-027 After resetn deasserts, the first start SHALL be accepted normally, with no residual state from an aborted operation.

Structure
REQ-028 The op control codes and the state encodings SHALL live in the shared defines header, not be redefined locally.
REQ-029 The iterative restoring divider datapath SHALL be a sub-module div_iter, WIDTH-parametrised and stepped by muldiv_unit.

Verification (WIDTH=32)
REQ-030 MULT a=FFFFFFFD (-3), b=00000005 -> done after 33 cycles, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-031 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; with MUL_ITER=0 the same result after 1 cycle.
REQ-032 DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-033 DIVU a=00000010, b=0 -> lo=FFFFFFFF, hi=00000010, done after 33 cycles.
REQ-034 Flush 5 cycles after a DIV start -> busy low the next cycle, no done, hi/lo unchanged; an immediately following MULTU 2*3 gives lo=00000006.
REQ-035 resetn pulsed low mid-MULT -> all outputs 0 asynchronously, no done; start while busy and start with op=AND_CONTROL are both ignored.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// +-----------------------------------------------------------------+
// | muldiv_unit_pkg : op control codes and FSM encoding shared by    |
// | the multiply/divide unit.                  Revision: 1.0         |
// +-----------------------------------------------------------------+
`default_nettype none

package muldiv_unit_pkg;

   localparam logic [4:0] AND_CONTROL   = 5'h00;
   localparam logic [4:0] MULT_CONTROL  = 5'h18;
   localparam logic [4:0] MULTU_CONTROL = 5'h19;
   localparam logic [4:0] DIV_CONTROL   = 5'h1A;
   localparam logic [4:0] DIVU_CONTROL  = 5'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_t;

   function automatic logic op_is_muldiv(input logic [4:0] op);
      return (op == MULT_CONTROL) || (op == MULTU_CONTROL) ||
             (op == DIV_CONTROL)  || (op == DIVU_CONTROL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter.sv
// +-----------------------------------------------------------------+
// | div_iter : restoring divider datapath, one quotient bit per      |
// | step, loaded and stepped by the owning FSM.  Revision: 1.0       |
// +-----------------------------------------------------------------+
`default_nettype none

module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             ge;

   // The dividend shifts out of quo_q MSB-first while quotient bits enter at the LSB.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr_q};
   assign ge      = (shifted >= {1'b0, dvsr_q});

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvsr_d = dvsr_q;
      if (load) begin
         rem_d  = '0;
         quo_d  = dividend;
         dvsr_d = divisor;
      end else if (step) begin
         rem_d = WIDTH'(ge ? diff : shifted);
         quo_d = {quo_q[WIDTH-2:0], ge};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvsr_q <= dvsr_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +-----------------------------------------------------------------+
// | muldiv_unit : iterative signed/unsigned multiply and divide      |
// | with stall, flush and one-cycle done pulse.  Revision: 1.0       |
// +-----------------------------------------------------------------+
`default_nettype none

module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_ITER = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [4:0]       op,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               op_signed, op_div;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_quo, div_rem;
   logic               div_load, div_step;

   assign op_signed = (op == MULT_CONTROL) || (op == DIV_CONTROL);
   assign op_div    = (op == DIV_CONTROL)  || (op == DIVU_CONTROL);
   assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

   // Shift-add step: multiplier sits in the low half and drains out of bit 0.
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
   assign prod_fix = neg_res_q ? -prod_q : prod_q;

   div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .load      (div_load),
      .step      (div_step),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      mcand_d   = mcand_q;
      a_raw_d   = a_raw_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      is_div_d  = is_div_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      div_load  = 1'b0;
      div_step  = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && op_is_muldiv(op)) begin
                  neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_d = op_signed && a[WIDTH-1];
                  a_raw_d   = a;
                  div0_d    = (b == '0);
                  is_div_d  = op_div;
                  cnt_d     = CW'(WIDTH);
                  if (op_div) begin
                     div_load = 1'b1;
                     state_d  = DIV;
                  end else begin
                     mcand_d = a_mag;
                     if (MUL_ITER != 0) begin
                        prod_d  = {{WIDTH{1'b0}}, b_mag};
                        state_d = MUL;
                     end else begin
                        prod_d  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                        state_d = FIN;
                     end
                  end
               end
            end
            MUL: begin
               prod_d = {mul_sum, prod_q[WIDTH-1:1]};
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = FIN;
            end
            DIV: begin
               div_step = 1'b1;
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = FIN;
            end
            FIN: begin
               if (is_div_q) begin
                  lo_d = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? -div_quo : div_quo);
                  hi_d = div0_q ? a_raw_q       : (neg_rem_q ? -div_rem : div_rem);
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         prod_q    <= '0;
         mcand_q   <= '0;
         a_raw_q   <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         is_div_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         mcand_q   <= mcand_d;
         a_raw_q   <= a_raw_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         is_div_q  <= is_div_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +-----------------------------------------------------------------+
// | tb_muldiv_unit : directed + random checks of muldiv_unit against |
// | an arithmetic reference model.             Revision: 1.0         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn, start, start1, flush;
   logic [4:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, busy1, done1;
   logic [W-1:0] hi, lo, hi1, lo1;

   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] last_hi, last_lo;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W), .MUL_ITER(1)) dut (
      .clk(clk), .resetn(resetn), .op(op), .start(start), .flush(flush),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(W), .MUL_ITER(0)) dut1 (
      .clk(clk), .resetn(resetn), .op(op), .start(start1), .flush(flush),
      .a(a), .b(b), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference results straight from the arithmetic definition of each op.
   function automatic void model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
      logic signed [63:0] sp;
      logic [63:0]        up;
      h = '0;
      l = '0;
      case (o)
         MULT_CONTROL: begin
            sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            h  = sp[63:32];
            l  = sp[31:0];
         end
         MULTU_CONTROL: begin
            up = {32'b0, x} * {32'b0, y};
            h  = up[63:32];
            l  = up[31:0];
         end
         DIVU_CONTROL: begin
            if (y == 0) begin l = '1; h = x; end
            else begin l = x / y; h = x % y; end
         end
         DIV_CONTROL: begin
            if (y == 0) begin l = '1; h = x; end
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = x; h = '0; end
            else begin l = $signed(x) / $signed(y); h = $signed(x) % $signed(y); end
         end
         default: ;
      endcase
   endfunction

   task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit use1);
      @(negedge clk);
      op = o; a = x; b = y;
      if (use1) start1 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat, input logic [W-1:0] eh,
                            input logic [W-1:0] el, input bit use1);
      int k = 0;
      while (((use1 ? done1 : done) !== 1'b1) && k < 80) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
      chk({tag, "_hi"}, use1 ? hi1 : hi, eh);
      chk({tag, "_lo"}, use1 ? lo1 : lo, el);
      chk({tag, "_idle_at_done"}, use1 ? busy1 : busy, 0);
      @(negedge clk);
      chk({tag, "_pulse"}, use1 ? done1 : done, 0);
   endtask

   task automatic run_exp(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input bit use1);
      issue(o, x, y, use1);
      chk({tag, "_busy"}, use1 ? busy1 : busy, 1);
      if (use1) wait_done(tag, 1, eh, el, 1'b1);
      else begin
         wait_done(tag, W + 1, eh, el, 1'b0);
         last_hi = eh;
         last_lo = el;
      end
   endtask

   task automatic run_rand(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit use1);
      logic [W-1:0] eh, el;
      model(o, x, y, eh, el);
      run_exp(tag, o, x, y, eh, el, use1);
   endtask

   task automatic watch_quiet(input string tag, input int n);
      int d = 0;
      int bz = 0;
      repeat (n) begin
         @(negedge clk);
         if (done === 1'b1) d++;
         if (busy === 1'b1) bz++;
      end
      chk({tag, "_no_done"}, 64'(d), 0);
      chk({tag, "_no_busy"}, 64'(bz), 0);
      chk({tag, "_hi_held"}, hi, last_hi);
      chk({tag, "_lo_held"}, lo, last_lo);
   endtask

   initial begin
      logic [4:0]   ops [4];
      logic [4:0]   o;
      logic [W-1:0] x, y;
      int           k;
      ops = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL};

      resetn = 1'b0; start = 1'b0; start1 = 1'b0; flush = 1'b0;
      op = AND_CONTROL; a = '0; b = '0;
      last_hi = '0; last_lo = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_lo1", lo1, 0);
      resetn = 1'b1;

      // Directed corner cases with hand-derived results.
      run_exp("mult_m3x5", MULT_CONTROL, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_exp("multu_max", MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
      run_exp("multu_max_1cyc", MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b1);
      run_exp("div_m7d2", DIV_CONTROL, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_exp("div_ovf", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_exp("divu_by0", DIVU_CONTROL, 32'h10, 32'h0, 32'h10, 32'hFFFF_FFFF, 1'b0);
      run_exp("div_by0_neg", DIV_CONTROL, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
      run_exp("div_7dm2", DIV_CONTROL, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);

      // Random operations against the model.
      for (int i = 0; i < 20; i++) begin
         o = ops[$urandom_range(0, 3)];
         x = $urandom;
         case ($urandom_range(0, 7))
            0:       y = '0;
            1:       y = 32'hFFFF_FFFF;
            2:       y = W'($urandom_range(1, 15));
            3:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            default: y = $urandom;
         endcase
         run_rand($sformatf("rnd%0d", i), o, x, y, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         run_rand($sformatf("rnd1c%0d", i), ops[$urandom_range(0, 1)], $urandom, $urandom, 1'b1);
      end

      // Flush 5 cycles into a divide, then an immediate multiply.
      issue(DIV_CONTROL, 32'd100, 32'd7, 1'b0);
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      watch_quiet("flush", 40);
      run_exp("after_flush", MULTU_CONTROL, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0);

      // Flush and start together: start is dropped.
      @(negedge clk);
      op = MULT_CONTROL; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      watch_quiet("flush_start", 40);

      // Asynchronous reset in the middle of a multiply.
      issue(MULT_CONTROL, 32'd12345, 32'd678, 1'b0);
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      @(negedge clk);
      resetn = 1'b1;
      last_hi = '0;
      last_lo = '0;
      watch_quiet("post_rst", 40);

      // First op after reset, with a second start while busy that must be ignored.
      issue(MULTU_CONTROL, 32'd2, 32'd3, 1'b0);
      repeat (3) @(negedge clk);
      op = DIVU_CONTROL; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start", W + 1 - 4, 32'h0, 32'h6, 1'b0);
      last_hi = 32'h0;
      last_lo = 32'h6;

      // Unrecognised op is ignored.
      @(negedge clk);
      op = AND_CONTROL; a = 32'd7; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      watch_quiet("and_op", 40);

      // Back-to-back: new start issued in the cycle done is high.
      issue(MULTU_CONTROL, 32'd7, 32'd6, 1'b0);
      k = 0;
      while (done !== 1'b1 && k < 80) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_first_lo", lo, 32'd42);
      op = MULTU_CONTROL; a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accept_busy", busy, 1);
      wait_done("b2b_second", W + 1, 32'h0, 32'd81, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
